// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 8:1 mux.
// Each grant is bounded to MAX_HOLD cycles; a release hands over on the same edge.
module mux8_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] Req,
    output logic [2:0] Sel,
    output logic [7:0] Gnt,
    output logic       Valid
);

    localparam int unsigned N     = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [IDX_W-1:0]   r_sel;
    logic [IDX_W-1:0]   w_sel_nxt;
    logic [N-1:0]       r_gnt;
    logic [N-1:0]       w_gnt_nxt;
    logic               r_valid;
    logic               w_valid_nxt;

    logic [IDX_W-1:0]   w_ptr_rel;
    logic [IDX_W:0]     w_pick_idle;
    logic [IDX_W:0]     w_pick_rel;
    logic               w_keep;

    // Returns {found, index}: first set request searching cyclically from ptr.
    function automatic logic [IDX_W:0] rr_pick(input logic [N-1:0] req,
                                                input logic [IDX_W-1:0] ptr);
        logic [2*N-1:0]   dbl;
        logic [N-1:0]     rot;
        logic [IDX_W-1:0] off;
        logic             found;
        dbl   = {req, req} >> ptr;
        rot   = dbl[N-1:0];
        off   = '0;
        found = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off   = IDX_W'(i);
                found = 1'b1;
            end
        end
        return {found, IDX_W'(off + ptr)};
    endfunction

    assign w_ptr_rel   = r_sel + IDX_W'(1);
    assign w_pick_idle = rr_pick(Req, r_ptr);
    assign w_pick_rel  = rr_pick(Req, w_ptr_rel);
    assign w_keep      = Req[r_sel] && (r_cnt < CNT_W'(MAX_HOLD - 1));

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_gnt_nxt   = r_gnt;
        w_valid_nxt = r_valid;
        case (r_state)
            IDLE: begin
                if (w_pick_idle[IDX_W]) begin
                    w_state_nxt = GRANT;
                    w_sel_nxt   = w_pick_idle[IDX_W-1:0];
                    w_gnt_nxt   = N'(1) << w_pick_idle[IDX_W-1:0];
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (w_keep) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else begin
                    // Release: pointer moves past the outgoing grantee, Sel holds if idle.
                    w_ptr_nxt = w_ptr_rel;
                    w_cnt_nxt = '0;
                    if (w_pick_rel[IDX_W]) begin
                        w_sel_nxt   = w_pick_rel[IDX_W-1:0];
                        w_gnt_nxt   = N'(1) << w_pick_rel[IDX_W-1:0];
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                        w_valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_gnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_gnt   <= w_gnt_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign Sel   = r_sel;
    assign Gnt   = r_gnt;
    assign Valid = r_valid;

endmodule
